// File: rtl/if_id_stage_reg_if.sv
// ---------------------------------------------------------------------------
// if_id_stage_reg_if
//   Bundles the signals between fetch, the hazard/branch logic and decode
//   around the IF->ID stage register.
//   Parameters PC_W / INST_W / CNT_W must match the attached stage register.
//   master : fetch + control side (drives in_*, stall, flush; observes outputs)
//   slave  : the stage register itself
//   Signals:
//     in_valid, in_pc, in_inst   fetched instruction and its valid flag
//     stall, flush               hold / bubble requests
//     out_valid, out_pc, out_inst registered instruction to decode
//     stall_run, flush_cnt       saturating monitor counters
//     stall_timeout              stall_run has reached the watchdog limit
// ---------------------------------------------------------------------------
interface if_id_stage_reg_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  stall_run;
  logic [CNT_W-1:0]  flush_cnt;
  logic              stall_timeout;

  modport master (
    output in_valid, in_pc, in_inst, stall, flush,
    input  out_valid, out_pc, out_inst, stall_run, flush_cnt, stall_timeout
  );

  modport slave (
    input  in_valid, in_pc, in_inst, stall, flush,
    output out_valid, out_pc, out_inst, stall_run, flush_cnt, stall_timeout
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// ---------------------------------------------------------------------------
// if_id_stage_reg
//   IF->ID pipeline register with valid tracking, true stall-hold, flush to
//   bubble, and stall/flush monitoring (stall-run counter with watchdog,
//   flush counter). Every output is a register; in->out latency is 1 cycle.
//   Edge priority: flush > stall > load.
//   Ports:
//     clk  clock, all state on rising edge
//     rst  asynchronous, active-low reset
//     bus  if_id_stage_reg_if.slave (inputs from fetch/control, outputs to
//          decode and monitors)
// ---------------------------------------------------------------------------
module if_id_stage_reg #(
  parameter int                PC_W      = 32,
  parameter int                INST_W    = 32,
  parameter logic [INST_W-1:0] NOP_INST  = '0,
  parameter int                CNT_W     = 8,
  parameter int                MAX_STALL = 16
) (
  input  logic                clk,
  input  logic                rst,
  if_id_stage_reg_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

  logic              valid_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [INST_W-1:0] inst_reg;
  logic [CNT_W-1:0]  stall_run_reg;
  logic [CNT_W-1:0]  stall_run_next;
  logic [CNT_W-1:0]  flush_cnt_reg;
  logic              timeout_reg;
  logic              hold;

  // A flush overrides a stall, so it also breaks the stall run.
  assign hold = bus.stall & ~bus.flush;

  always_comb begin
    stall_run_next = '0;
    if (hold) begin
      stall_run_next = (stall_run_reg == CNT_MAX) ? CNT_MAX
                                                  : stall_run_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      inst_reg      <= NOP_INST;
      stall_run_reg <= '0;
      flush_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      if (bus.flush) begin
        valid_reg <= 1'b0;
        pc_reg    <= '0;
        inst_reg  <= NOP_INST;
      end else if (!bus.stall) begin
        // An invalid fetch still carries its PC, but the instruction becomes a NOP.
        valid_reg <= bus.in_valid;
        pc_reg    <= bus.in_pc;
        inst_reg  <= bus.in_valid ? bus.in_inst : NOP_INST;
      end
      // stall with no flush: the data registers simply keep their value.

      stall_run_reg <= stall_run_next;
      // Watchdog tracks the counter value being written on this same edge.
      timeout_reg   <= (stall_run_next >= STALL_LIMIT);

      if (bus.flush && (flush_cnt_reg != CNT_MAX)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid     = valid_reg;
  assign bus.out_pc        = pc_reg;
  assign bus.out_inst      = inst_reg;
  assign bus.stall_run     = stall_run_reg;
  assign bus.flush_cnt     = flush_cnt_reg;
  assign bus.stall_timeout = timeout_reg;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage_reg
//   Directed bench for if_id_stage_reg. Instance A uses 8-bit counters and a
//   watchdog of 16 with a non-zero NOP encoding; instance B uses 4-bit
//   counters (watchdog 12) to exercise saturation.
// ---------------------------------------------------------------------------
module tb_if_id_stage_reg;

  localparam logic [31:0] NOP_A = 32'h0000_0013;
  localparam logic [31:0] NOP_B = 32'h0000_0000;

  logic clk;
  logic rst;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  if_id_stage_reg_if #(.PC_W(32), .INST_W(32), .CNT_W(8)) bus_a ();
  if_id_stage_reg_if #(.PC_W(32), .INST_W(32), .CNT_W(4)) bus_b ();

  if_id_stage_reg #(
    .PC_W(32), .INST_W(32), .NOP_INST(NOP_A), .CNT_W(8), .MAX_STALL(16)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  if_id_stage_reg #(
    .PC_W(32), .INST_W(32), .NOP_INST(NOP_B), .CNT_W(4), .MAX_STALL(12)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-22s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_pc = '0; bus_a.in_inst = '0;
    bus_a.stall = 1'b0;    bus_a.flush = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_pc = '0; bus_b.in_inst = '0;
    bus_b.stall = 1'b0;    bus_b.flush = 1'b0;

    // Reset state
    #12;
    check("rst_valid",   64'(bus_a.out_valid), 64'd0);
    check("rst_pc",      64'(bus_a.out_pc), 64'd0);
    check("rst_inst",    64'(bus_a.out_inst), 64'(NOP_A));
    check("rst_srun",    64'(bus_a.stall_run), 64'd0);
    check("rst_fcnt",    64'(bus_a.flush_cnt), 64'd0);
    check("rst_tmo",     64'(bus_a.stall_timeout), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Load and 1-cycle latency
    bus_a.in_valid = 1'b1; bus_a.in_pc = 32'h100; bus_a.in_inst = 32'h8C22_0004;
    tick();
    check("load_valid",  64'(bus_a.out_valid), 64'd1);
    check("load_pc",     64'(bus_a.out_pc), 64'h100);
    check("load_inst",   64'(bus_a.out_inst), 64'h8C22_0004);
    bus_a.in_valid = 1'b0; bus_a.in_pc = 32'h200; bus_a.in_inst = 32'hDEAD_BEEF;
    tick();
    check("bubble_valid", 64'(bus_a.out_valid), 64'd0);
    check("bubble_pc",    64'(bus_a.out_pc), 64'h200);
    check("bubble_inst",  64'(bus_a.out_inst), 64'(NOP_A));

    // Stall hold
    bus_a.in_valid = 1'b1; bus_a.in_pc = 32'h104; bus_a.in_inst = 32'h0022_1820;
    tick();
    check("pre_stall_pc", 64'(bus_a.out_pc), 64'h104);
    bus_a.stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus_a.in_pc = 32'h300 + 32'(i); bus_a.in_inst = 32'hAAAA_0000 + 32'(i);
      bus_a.in_valid = (i % 2 == 0);
      tick();
      check($sformatf("hold%0d_valid", i), 64'(bus_a.out_valid), 64'd1);
      check($sformatf("hold%0d_pc", i),    64'(bus_a.out_pc), 64'h104);
      check($sformatf("hold%0d_inst", i),  64'(bus_a.out_inst), 64'h0022_1820);
      check($sformatf("hold%0d_srun", i),  64'(bus_a.stall_run), 64'(i));
    end
    bus_a.stall = 1'b0; bus_a.in_valid = 1'b1;
    bus_a.in_pc = 32'h108; bus_a.in_inst = 32'h1111_1111;
    tick();
    check("unstall_pc",   64'(bus_a.out_pc), 64'h108);
    check("unstall_inst", 64'(bus_a.out_inst), 64'h1111_1111);
    check("unstall_srun", 64'(bus_a.stall_run), 64'd0);

    // Flush priority over stall
    bus_a.stall = 1'b1;
    tick();
    check("pf_srun", 64'(bus_a.stall_run), 64'd1);
    bus_a.flush = 1'b1;
    tick();
    check("flush_valid", 64'(bus_a.out_valid), 64'd0);
    check("flush_pc",    64'(bus_a.out_pc), 64'd0);
    check("flush_inst",  64'(bus_a.out_inst), 64'(NOP_A));
    check("flush_srun",  64'(bus_a.stall_run), 64'd0);
    check("flush_fcnt",  64'(bus_a.flush_cnt), 64'd1);

    // Flush pulse between edges is ignored
    bus_a.flush = 1'b0; bus_a.stall = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_pc = 32'h10C; bus_a.in_inst = 32'h2222_2222;
    #2 bus_a.flush = 1'b1;
    #2 bus_a.flush = 1'b0;
    tick();
    check("glitch_fcnt",  64'(bus_a.flush_cnt), 64'd1);
    check("glitch_valid", 64'(bus_a.out_valid), 64'd1);
    check("glitch_pc",    64'(bus_a.out_pc), 64'h10C);

    // Watchdog
    bus_a.stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("wd%0d_srun", i), 64'(bus_a.stall_run), 64'(i));
      check($sformatf("wd%0d_tmo", i),  64'(bus_a.stall_timeout), 64'(i >= 16));
    end
    check("wd_hold_pc", 64'(bus_a.out_pc), 64'h10C);
    bus_a.stall = 1'b0;
    tick();
    check("wd_end_tmo",  64'(bus_a.stall_timeout), 64'd0);
    check("wd_end_srun", 64'(bus_a.stall_run), 64'd0);

    // Asynchronous reset mid-run
    check("pre_rst_valid", 64'(bus_a.out_valid), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(bus_a.out_valid), 64'd0);
    check("arst_pc",    64'(bus_a.out_pc), 64'd0);
    check("arst_inst",  64'(bus_a.out_inst), 64'(NOP_A));
    check("arst_fcnt",  64'(bus_a.flush_cnt), 64'd0);
    check("arst_srun",  64'(bus_a.stall_run), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Saturation on the 4-bit instance
    bus_b.flush = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("sat_f%0d", i), 64'(bus_b.flush_cnt), 64'((i > 15) ? 15 : i));
    end
    bus_b.flush = 1'b0; bus_b.stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("sat_s%0d", i),   64'(bus_b.stall_run), 64'((i > 15) ? 15 : i));
      check($sformatf("sat_tmo%0d", i), 64'(bus_b.stall_timeout), 64'(i >= 12));
    end
    bus_b.stall = 1'b0;
    tick();
    check("sat_end_srun", 64'(bus_b.stall_run), 64'd0);
    check("sat_end_fcnt", 64'(bus_b.flush_cnt), 64'd15);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
